ecap5_dwbgpio: RTL

Wishbone pipelined slave GPIO peripheral driving the LED outputs and sampling the button inputs of the SoC. Sits downstream of the SoC memory-mapping logic as a third slave alongside BRAM and UART, in its own address window. Provides:
- a writable output register;
- synchronised, debounced inputs;
- sticky rising-edge flags that software clears.

---
 rtl/ecap5_dwbgpio.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ecap5_dwbgpio.sv
// ecap5_dwbgpio: Wishbone pipelined GPIO slave.
// Provides a writable output register, synchronised and debounced inputs, and
// sticky rising-edge flags with write-one-to-clear.
// Optional feature: define ECAP5_DWBGPIO_IRQ_EN to add the IRQEN register
// (offset 0x10) and the registered irq_o output.
module ecap5_dwbgpio #(
    parameter int NB_OUT          = 2,
    parameter int NB_IN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    input  logic              wb_cyc_i,
    output logic              wb_stall_o,
    output logic [NB_OUT-1:0] gpio_o,
`ifdef ECAP5_DWBGPIO_IRQ_EN
    output logic              irq_o,
`endif
    input  logic [NB_IN-1:0]  gpio_i
);

    localparam logic [2:0]  REG_OUT   = 3'd0;
    localparam logic [2:0]  REG_IN    = 3'd1;
    localparam logic [2:0]  REG_EDGE  = 3'd2;
    localparam logic [2:0]  REG_INFO  = 3'd3;
`ifdef ECAP5_DWBGPIO_IRQ_EN
    localparam logic [2:0]  REG_IRQEN = 3'd4;
`endif
    // The counter only ever counts up to this value, so it cannot wrap.
    localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);

    logic              accept, wr;
    logic [2:0]        reg_idx;
    logic [31:0]       lane_mask, wr_bits, rd_data;

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [NB_OUT-1:0] out_q, out_d;

    logic [NB_IN-1:0]        sync1_q, sync2_q;
    logic [NB_IN-1:0]        in_q, in_d, in_prev_q, rise;
    logic [NB_IN-1:0]        edge_q, edge_d;
    logic [NB_IN-1:0][19:0]  cnt_q, cnt_d;

`ifdef ECAP5_DWBGPIO_IRQ_EN
    logic [NB_IN-1:0]  irqen_q, irqen_d;
    logic              irq_q, irq_d;
`endif

    // No wait states: every strobed cycle inside a bus cycle is a transfer.
    assign accept    = wb_cyc_i & wb_stb_i;
    assign wr        = accept & wb_we_i;
    assign reg_idx   = wb_adr_i[4:2];
    assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wr_bits   = wb_dat_i & lane_mask;

    // Address bits outside the register window and data bits above the
    // implemented register widths are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0], wr_bits};

    // Read mux over the current register values; unmapped offsets return 0.
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_OUT:   rd_data[NB_OUT-1:0] = out_q;
            REG_IN:    rd_data[NB_IN-1:0]  = in_q;
            REG_EDGE:  rd_data[NB_IN-1:0]  = edge_q;
            REG_INFO:  rd_data[15:0]       = {8'(NB_IN), 8'(NB_OUT)};
`ifdef ECAP5_DWBGPIO_IRQ_EN
            REG_IRQEN: rd_data[NB_IN-1:0]  = irqen_q;
`endif
            default:   rd_data = '0;
        endcase
    end

    // Bus response and writable registers; byte lanes gate every write.
    always_comb begin
        ack_d = accept;
        dat_d = (accept && !wb_we_i) ? rd_data : '0;
        out_d = out_q;
        if (wr && reg_idx == REG_OUT)
            out_d = (out_q & ~lane_mask[NB_OUT-1:0]) | wr_bits[NB_OUT-1:0];
`ifdef ECAP5_DWBGPIO_IRQ_EN
        irqen_d = irqen_q;
        if (wr && reg_idx == REG_IRQEN)
            irqen_d = (irqen_q & ~lane_mask[NB_IN-1:0]) | wr_bits[NB_IN-1:0];
        irq_d = |(edge_q & irqen_q);
`endif
    end

    // Per-bit debounce: IN follows the synchronised pin only after it has
    // disagreed with IN for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        in_d  = in_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NB_IN; i++) begin
            if (sync2_q[i] == in_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                in_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 20'd1;
            end
        end
    end

    // Sticky rise flags; a new rise takes priority over a same-cycle clear.
    always_comb begin
        rise   = in_q & ~in_prev_q;
        edge_d = edge_q;
        if (wr && reg_idx == REG_EDGE)
            edge_d = edge_q & ~wr_bits[NB_IN-1:0];
        edge_d = edge_d | rise;
    end

    // Bus-side state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            out_q   <= '0;
`ifdef ECAP5_DWBGPIO_IRQ_EN
            irqen_q <= '0;
            irq_q   <= 1'b0;
`endif
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            out_q   <= out_d;
`ifdef ECAP5_DWBGPIO_IRQ_EN
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
`endif
        end
    end

    // Input path: synchroniser, debounce counters, IN and edge flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            in_q      <= '0;
            in_prev_q <= '0;
            edge_q    <= '0;
        end else begin
            sync1_q   <= gpio_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            in_q      <= in_d;
            in_prev_q <= in_q;
            edge_q    <= edge_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign wb_stall_o = 1'b0;
    assign gpio_o     = out_q;
`ifdef ECAP5_DWBGPIO_IRQ_EN
    assign irq_o      = irq_q;
`endif

endmodule
